// File: rtl/store_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : store_write_buffer_pkg
//  Brief   : Shared constants for the posted-store write buffer
//  Revision: 1.0 - initial release
// ============================================================================
package store_write_buffer_pkg;

   // Default number of queue entries (power of 2, >= 2)
   localparam int unsigned C_SWB_DEPTH    = 4;
   // Low address bits ignored by the word compare (byte offset in a word)
   localparam int unsigned C_SWB_WORD_OFS = 2;

   // Pointer width for a given depth; at least one bit
   function automatic int unsigned swb_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Pointer width for the default depth
   localparam int unsigned C_SWB_PTR_W = swb_ptr_w(C_SWB_DEPTH);

endpackage
`default_nettype wire

// File: rtl/store_write_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : swb_fifo
//  Brief   : Circular store queue with head/tail/count and a per-entry
//            valid/addr/data view for the lookup logic in the parent
//  Revision: 1.0 - initial release
// ============================================================================
module swb_fifo
   import store_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = C_SWB_DEPTH,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned PW    = swb_ptr_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [AW-1:0]     push_addr_i,
   input  logic [DW-1:0]     push_data_i,
   input  logic              pop_i,
   output logic [AW-1:0]     head_addr_o,
   output logic [DW-1:0]     head_data_o,
   output logic [PW-1:0]     head_o,
   output logic [DEPTH-1:0]  valid_o,
   output logic [DEPTH*AW-1:0] addr_flat_o,
   output logic [DEPTH*DW-1:0] data_flat_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_push, w_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // Guard against caller misuse so the counters can never over/underflow
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   // Next-state for pointers, occupancy and valid bits
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (w_push) begin
         tail_d          = tail_q + PW'(1);
         valid_d[tail_q] = 1'b1;
      end
      if (w_pop) begin
         head_d          = head_q + PW'(1);
         valid_d[head_q] = 1'b0;
      end
      if (w_push && !w_pop) count_d = count_q + CW'(1);
      else if (!w_push && w_pop) count_d = count_q - CW'(1);
   end

   // Control state register; reset discards every pending entry
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry payload storage; contents are qualified by valid_q so no reset
   always_ff @(posedge clk_i) begin
      if (rst_i && w_push) begin
         addr_q[tail_q] <= push_addr_i;
         data_q[tail_q] <= push_data_i;
      end
   end

   assign head_addr_o = addr_q[head_q];
   assign head_data_o = data_q[head_q];
   assign head_o      = head_q;
   assign valid_o     = valid_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign addr_flat_o[i*AW +: AW] = addr_q[i];
      assign data_flat_o[i*DW +: DW] = data_q[i];
   end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : store_write_buffer
//  Brief   : Posted-store queue in front of a single-port data memory.
//            Stores retire in the background; loads see the youngest
//            queued store to the same word, otherwise memory data.
//  Revision: 1.0 - initial release
// ============================================================================
module store_write_buffer
   import store_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = C_SWB_DEPTH,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          st_i,
   input  logic          ld_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wrdata_i,
   output logic [DW-1:0] rddata_o,
   output logic          stall_o,
   output logic          empty_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wrdata_o,
   output logic          mem_wr_o,
   output logic          mem_rd_o,
   input  logic [DW-1:0] mem_rddata_i
);

   localparam int unsigned PW = swb_ptr_w(DEPTH);

   logic [AW-1:0]       w_head_addr;
   logic [DW-1:0]       w_head_data;
   logic [PW-1:0]       w_head;
   logic [DEPTH-1:0]    w_valid;
   logic [DEPTH*AW-1:0] w_addr_flat;
   logic [DEPTH*DW-1:0] w_data_flat;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_drain;
   logic                w_hit;
   logic [DW-1:0]       w_hit_data;
   logic [PW-1:0]       w_idx;

   // Full is judged on the registered count, so a same-cycle drain does
   // not open a slot until the following cycle
   assign w_push  = st_i & ~w_full;
   assign stall_o = st_i & w_full;
   // A load owns the memory port; drains wait for a load-free cycle
   assign w_drain = ~w_empty & ~ld_i;

   swb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .PW    (PW)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_push),
      .push_addr_i (addr_i),
      .push_data_i (wrdata_i),
      .pop_i       (w_drain),
      .head_addr_o (w_head_addr),
      .head_data_o (w_head_data),
      .head_o      (w_head),
      .valid_o     (w_valid),
      .addr_flat_o (w_addr_flat),
      .data_flat_o (w_data_flat),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   // Youngest-match search: walk oldest (head) to newest, later hits win
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = w_head + PW'(k);
         if (w_valid[w_idx] &&
             (w_addr_flat[w_idx*AW + C_SWB_WORD_OFS +: AW-C_SWB_WORD_OFS] ==
              addr_i[AW-1:C_SWB_WORD_OFS])) begin
            w_hit      = 1'b1;
            w_hit_data = w_data_flat[w_idx*DW +: DW];
         end
      end
   end

   assign rddata_o     = !ld_i ? '0 : (w_hit ? w_hit_data : mem_rddata_i);
   assign empty_o      = w_empty;
   assign mem_wr_o     = w_drain;
   assign mem_rd_o     = ld_i;
   assign mem_addr_o   = ld_i ? addr_i : w_head_addr;
   assign mem_wrdata_o = w_head_data;

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_store_write_buffer
//  Brief   : Scoreboard bench for store_write_buffer
//  Revision: 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        st_i = 1'b0, ld_i = 1'b0;
   logic [31:0] addr_i = '0, wrdata_i = '0, mem_rddata_i = 32'hDEAD_BEEF;
   logic [31:0] rddata_o, mem_addr_o, mem_wrdata_o;
   logic        stall_o, empty_o, mem_wr_o, mem_rd_o;

   always #5 clk_i = ~clk_i;

   store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .st_i         (st_i),
      .ld_i         (ld_i),
      .addr_i       (addr_i),
      .wrdata_i     (wrdata_i),
      .rddata_o     (rddata_o),
      .stall_o      (stall_o),
      .empty_o      (empty_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wrdata_o (mem_wrdata_o),
      .mem_wr_o     (mem_wr_o),
      .mem_rd_o     (mem_rd_o),
      .mem_rddata_i (mem_rddata_i)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t sb[$];   // stores accepted but not yet drained, oldest first
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drain monitor: memory writes must match the oldest queued store
   always @(negedge clk_i) begin
      ent_t e;
      if (!rst_i) begin
         sb.delete();
      end else begin
         check("drain_en", {63'd0, mem_wr_o}, {63'd0, (sb.size() > 0) && !ld_i});
         check("empty", {63'd0, empty_o}, {63'd0, sb.size() == 0});
         if (!ld_i) check("rd_idle", {32'd0, rddata_o}, 64'd0);
         if (mem_wr_o && sb.size() > 0) begin
            e = sb.pop_front();
            check("drain_addr", {32'd0, mem_addr_o}, {32'd0, e.a});
            check("drain_data", {32'd0, mem_wrdata_o}, {32'd0, e.d});
         end
      end
   end

   // Store request; ld_i is held high for the first ld_cycles attempts
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int ld_cycles);
      bit accepted = 0;
      bit exp_stall;
      for (int t = 0; t < 10; t++) begin
         st_i = 1'b1; addr_i = a; wrdata_i = d; ld_i = (t < ld_cycles);
         exp_stall = (sb.size() == 4);
         @(negedge clk_i); #1;
         check("stall", {63'd0, stall_o}, {63'd0, exp_stall});
         if (!exp_stall) begin
            sb.push_back('{a: a, d: d});
            accepted = 1;
         end
         @(posedge clk_i); #1;
         if (accepted) break;
      end
      st_i = 1'b0; ld_i = 1'b0;
      if (!accepted) check("store_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] md);
      logic [31:0] exp;
      ld_i = 1'b1; addr_i = a; mem_rddata_i = md;
      @(negedge clk_i); #1;
      exp = md;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].a[31:2] == a[31:2]) begin
            exp = sb[i].d;
            break;
         end
      check("ld_data", {32'd0, rddata_o}, {32'd0, exp});
      check("ld_rd", {63'd0, mem_rd_o}, 64'd1);
      check("ld_nowr", {63'd0, mem_wr_o}, 64'd0);
      check("ld_addr", {32'd0, mem_addr_o}, {32'd0, a});
      @(posedge clk_i); #1;
      ld_i = 1'b0; mem_rddata_i = 32'hDEAD_BEEF;
   endtask

   task automatic wait_empty();
      bit done = 0;
      for (int t = 0; t < 50; t++) begin
         @(posedge clk_i); #1;
         if (sb.size() == 0 && empty_o) begin
            done = 1;
            break;
         end
      end
      check("drain_timeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(negedge clk_i); #1;
      check("rst_empty", {63'd0, empty_o}, 64'd1);
      check("rst_stall", {63'd0, stall_o}, 64'd0);
      check("rst_wr", {63'd0, mem_wr_o}, 64'd0);
      @(posedge clk_i); #1;

      // 1: reset discards queued stores
      do_store(32'h40, 32'h1111, 1);
      do_store(32'h44, 32'h2222, 1);
      ld_i = 1'b1;                 // keep entries from draining
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1; ld_i = 1'b0;
      @(negedge clk_i); #1;
      check("t1_empty", {63'd0, empty_o}, 64'd1);
      check("t1_wr", {63'd0, mem_wr_o}, 64'd0);
      @(posedge clk_i); #1;
      do_load(32'h40, 32'h5A5A_0001);

      // 2: forward from queue, then drain on the idle cycle
      do_store(32'h10, 32'hAAAA, 0);
      do_load(32'h10, 32'h0BAD);
      wait_empty();

      // 3: two stores to the same word, load sees the newer one
      do_store(32'h20, 32'h1, 1);
      do_store(32'h20, 32'h2, 1);
      do_load(32'h20, 32'h0BAD);
      wait_empty();

      // 4: fill to DEPTH with loads blocking drains, then stall/release
      for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(i*4), 32'hC0 + 32'(i), 100);
      do_store(32'h200, 32'hF5, 1);
      wait_empty();

      // 5: push during drain at count 2, then wrap with 9 stores
      do_store(32'h300, 32'h30, 1);
      do_store(32'h304, 32'h31, 1);
      do_store(32'h308, 32'h32, 0);
      for (int i = 0; i < 9; i++) do_store(32'h400 + 32'(i*4), 32'h900 + 32'(i), 0);
      wait_empty();

      // 6: miss reads memory; byte address matches its word
      do_load(32'h30, 32'h1234);
      do_store(32'h10, 32'h55, 0);
      do_load(32'h12, 32'h0BAD);
      wait_empty();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
